// File: rtl/card_board.sv
// card_board: responder end of the memory-game open interface.
// Holds the card face values, accepts or refuses open requests, tracks which
// cards are face-up and which are paired, compares each pair of opens, keeps
// both players' scores and flags when every pair has been found.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   load_en/load_idx/load_val   write a card face value (IDLE, nothing matched yet)
//   open_en/open_idx            request to reveal a card (single-cycle pulse)
//   turn                        current player, sampled at pair compare
//   force_hide                  abort: hide the unpaired face-up card
//   open_ack/open_rej/open_val  registered answer to an open request
//   revealed/matched            per-card face-up / permanently-paired flags
//   pair_valid/pair_match       pair comparison result pulse
//   busy                        mismatch display in progress
//   pairs_left/score0/score1    game counters
//   all_matched                 level: no pairs left
//
// state     | meaning
// ----------+-----------------------------------------------------
// IDLE      | no unpaired card face-up
// ONE_OPEN  | first card of a pair face-up (idx1)
// COMPARE   | second card accepted (idx2), comparing this cycle
// SHOW_MISS | mismatched pair shown, hide counter running
module card_board #(
    parameter int N_CARDS     = 16,
    parameter int IDX_W       = 4,
    parameter int VAL_W       = 3,
    parameter int HIDE_CYCLES = 50_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [IDX_W-1:0]   load_idx,
    input  logic [VAL_W-1:0]   load_val,
    input  logic               open_en,
    input  logic [IDX_W-1:0]   open_idx,
    input  logic               turn,
    input  logic               force_hide,
    output logic               open_ack,
    output logic               open_rej,
    output logic [VAL_W-1:0]   open_val,
    output logic [N_CARDS-1:0] revealed,
    output logic [N_CARDS-1:0] matched,
    output logic               pair_valid,
    output logic               pair_match,
    output logic               busy,
    output logic [IDX_W-1:0]   pairs_left,
    output logic [IDX_W-1:0]   score0,
    output logic [IDX_W-1:0]   score1,
    output logic               all_matched
);

    localparam int               CNT_W    = (HIDE_CYCLES > 1) ? $clog2(HIDE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HIDE_CYCLES - 1);
    localparam logic [IDX_W-1:0] N_PAIRS  = IDX_W'(N_CARDS / 2);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ONE_OPEN  = 2'd1,
        COMPARE   = 2'd2,
        SHOW_MISS = 2'd3
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx1;
    logic [IDX_W-1:0] idx2;
    logic [CNT_W-1:0] hide_cnt;
    logic [VAL_W-1:0] card_val [N_CARDS];
    logic             open_ok;

    assign all_matched = (pairs_left == '0);

    // force_hide in ONE_OPEN wins over a same-cycle open, so that open is refused.
    assign open_ok = ((state == IDLE) || (state == ONE_OPEN && !force_hide))
                     && !revealed[open_idx] && !all_matched;

    // Card RAM survives rst; a same-cycle open takes precedence over a load.
    always_ff @(posedge clk) begin
        if (!rst && load_en && !open_en && state == IDLE && matched == '0)
            card_val[load_idx] <= load_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx1       <= '0;
            idx2       <= '0;
            hide_cnt   <= '0;
            open_ack   <= 1'b0;
            open_rej   <= 1'b0;
            open_val   <= '0;
            revealed   <= '0;
            matched    <= '0;
            pair_valid <= 1'b0;
            pair_match <= 1'b0;
            busy       <= 1'b0;
            pairs_left <= N_PAIRS;
            score0     <= '0;
            score1     <= '0;
        end else begin
            open_ack   <= 1'b0;
            open_rej   <= 1'b0;
            pair_valid <= 1'b0;
            pair_match <= 1'b0;

            if (open_en) begin
                if (open_ok) begin
                    open_ack           <= 1'b1;
                    open_val           <= card_val[open_idx];
                    revealed[open_idx] <= 1'b1;
                end else begin
                    open_rej <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (open_en && open_ok) begin
                        idx1  <= open_idx;
                        state <= ONE_OPEN;
                    end
                end
                ONE_OPEN: begin
                    if (force_hide) begin
                        revealed[idx1] <= 1'b0;
                        state          <= IDLE;
                    end else if (open_en && open_ok) begin
                        idx2  <= open_idx;
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    pair_valid <= 1'b1;
                    if (card_val[idx1] == card_val[idx2]) begin
                        pair_match    <= 1'b1;
                        matched[idx1] <= 1'b1;
                        matched[idx2] <= 1'b1;
                        if (pairs_left != '0)
                            pairs_left <= pairs_left - IDX_W'(1);
                        if (turn) begin
                            if (score1 != N_PAIRS) score1 <= score1 + IDX_W'(1);
                        end else begin
                            if (score0 != N_PAIRS) score0 <= score0 + IDX_W'(1);
                        end
                        state <= IDLE;
                    end else begin
                        busy     <= 1'b1;
                        hide_cnt <= CNT_LOAD;
                        state    <= SHOW_MISS;
                    end
                end
                SHOW_MISS: begin
                    // Loaded with HIDE_CYCLES-1, so busy spans HIDE_CYCLES cycles.
                    if (hide_cnt == '0) begin
                        revealed[idx1] <= 1'b0;
                        revealed[idx2] <= 1'b0;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        hide_cnt <= hide_cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_card_board.sv
// Directed bench for card_board with HIDE_CYCLES=4: a table of one-cycle
// vectors plus hand sequences for load/open interaction, a full game and a
// reset during the mismatch display.
module tb_card_board;

    logic        clk;
    logic        rst;
    logic        load_en;
    logic [3:0]  load_idx;
    logic [2:0]  load_val;
    logic        open_en;
    logic [3:0]  open_idx;
    logic        turn;
    logic        force_hide;
    logic        open_ack;
    logic        open_rej;
    logic [2:0]  open_val;
    logic [15:0] revealed;
    logic [15:0] matched;
    logic        pair_valid;
    logic        pair_match;
    logic        busy;
    logic [3:0]  pairs_left;
    logic [3:0]  score0;
    logic [3:0]  score1;
    logic        all_matched;

    int tests;
    int fails;

    card_board #(
        .N_CARDS(16), .IDX_W(4), .VAL_W(3), .HIDE_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .load_en(load_en), .load_idx(load_idx), .load_val(load_val),
        .open_en(open_en), .open_idx(open_idx), .turn(turn), .force_hide(force_hide),
        .open_ack(open_ack), .open_rej(open_rej), .open_val(open_val),
        .revealed(revealed), .matched(matched),
        .pair_valid(pair_valid), .pair_match(pair_match), .busy(busy),
        .pairs_left(pairs_left), .score0(score0), .score1(score1),
        .all_matched(all_matched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fields are ints so the table below can use plain literals.
    typedef struct {
        int rst, ld, li, lv, oe, oi, tu, fh;
        int ack, rej, oval, rev, mat, pv, pm, busy, pl, s0, s1;
    } vec_t;

    vec_t vecs[25];

    function automatic logic [63:0] dut_outs();
        return 64'({open_ack, open_rej, open_val, revealed, matched,
                    pair_valid, pair_match, busy, pairs_left, score0, score1, all_matched});
    endfunction

    function automatic logic [63:0] exp_outs(vec_t v);
        return 64'({1'(v.ack), 1'(v.rej), 3'(v.oval), 16'(v.rev), 16'(v.mat),
                    1'(v.pv), 1'(v.pm), 1'(v.busy), 4'(v.pl), 4'(v.s0), 4'(v.s1),
                    1'(v.pl == 0)});
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic clear_in();
        rst = 1'b0; load_en = 1'b0; load_idx = '0; load_val = '0;
        open_en = 1'b0; open_idx = '0; force_hide = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic open_card(input int idx);
        clear_in();
        open_en  = 1'b1;
        open_idx = 4'(idx);
        tick();
        clear_in();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tests = 0;
        fails = 0;
        turn  = 1'b0;
        clear_in();

        //   rst ld li lv oe oi tu fh | ack rej oval rev      mat      pv pm busy pl s0 s1
        vecs[0]  = '{0,0,0,0, 1,0, 0,0, 1,0,0,'h0001,'h0000,0,0,0,8,0,0};
        vecs[1]  = '{0,0,0,0, 1,1, 0,0, 1,0,0,'h0003,'h0000,0,0,0,8,0,0};
        vecs[2]  = '{0,0,0,0, 0,0, 0,0, 0,0,0,'h0003,'h0003,1,1,0,7,1,0};
        vecs[3]  = '{1,0,0,0, 0,0, 0,0, 0,0,0,'h0000,'h0000,0,0,0,8,0,0};
        vecs[4]  = '{0,0,0,0, 1,0, 0,0, 1,0,0,'h0001,'h0000,0,0,0,8,0,0};
        vecs[5]  = '{0,0,0,0, 1,2, 0,0, 1,0,1,'h0005,'h0000,0,0,0,8,0,0};
        vecs[6]  = '{0,0,0,0, 1,6, 0,0, 0,1,1,'h0005,'h0000,1,0,1,8,0,0};
        vecs[7]  = '{0,0,0,0, 1,6, 0,0, 0,1,1,'h0005,'h0000,0,0,1,8,0,0};
        vecs[8]  = '{0,0,0,0, 0,0, 0,0, 0,0,1,'h0005,'h0000,0,0,1,8,0,0};
        vecs[9]  = '{0,0,0,0, 0,0, 0,0, 0,0,1,'h0005,'h0000,0,0,1,8,0,0};
        vecs[10] = '{0,0,0,0, 0,0, 0,0, 0,0,1,'h0000,'h0000,0,0,0,8,0,0};
        vecs[11] = '{0,0,0,0, 1,5, 0,0, 1,0,2,'h0020,'h0000,0,0,0,8,0,0};
        vecs[12] = '{0,0,0,0, 1,5, 0,0, 0,1,2,'h0020,'h0000,0,0,0,8,0,0};
        vecs[13] = '{0,0,0,0, 1,4, 0,1, 0,1,2,'h0000,'h0000,0,0,0,8,0,0};
        vecs[14] = '{0,0,0,0, 1,3, 0,0, 1,0,1,'h0008,'h0000,0,0,0,8,0,0};
        vecs[15] = '{0,0,0,0, 1,4, 0,1, 0,1,1,'h0000,'h0000,0,0,0,8,0,0};
        vecs[16] = '{0,0,0,0, 1,4, 0,0, 1,0,2,'h0010,'h0000,0,0,0,8,0,0};
        vecs[17] = '{0,0,0,0, 1,5, 0,0, 1,0,2,'h0030,'h0000,0,0,0,8,0,0};
        vecs[18] = '{0,0,0,0, 0,0, 0,0, 0,0,2,'h0030,'h0030,1,1,0,7,1,0};
        vecs[19] = '{0,0,0,0, 1,5, 0,0, 0,1,2,'h0030,'h0030,0,0,0,7,1,0};
        vecs[20] = '{0,0,0,0, 0,0, 0,1, 0,0,2,'h0030,'h0030,0,0,0,7,1,0};
        vecs[21] = '{0,1,0,7, 0,0, 0,0, 0,0,2,'h0030,'h0030,0,0,0,7,1,0};
        vecs[22] = '{0,0,0,0, 1,0, 0,0, 1,0,0,'h0031,'h0030,0,0,0,7,1,0};
        vecs[23] = '{0,0,0,0, 1,1, 1,0, 1,0,0,'h0033,'h0030,0,0,0,7,1,0};
        vecs[24] = '{0,0,0,0, 0,0, 1,0, 0,0,0,'h0033,'h0033,1,1,0,6,1,1};

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("reset_state", dut_outs(),
            64'({1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd8, 4'd0, 4'd0, 1'b0}));
        clear_in();

        // Load {0,0,1,1,...,7,7}
        for (int i = 0; i < 16; i++) begin
            load_en  = 1'b1;
            load_idx = 4'(i);
            load_val = 3'(i / 2);
            tick();
        end
        clear_in();

        for (int i = 0; i < 25; i++) begin
            rst        = 1'(vecs[i].rst);
            load_en    = 1'(vecs[i].ld);
            load_idx   = 4'(vecs[i].li);
            load_val   = 3'(vecs[i].lv);
            open_en    = 1'(vecs[i].oe);
            open_idx   = 4'(vecs[i].oi);
            turn       = 1'(vecs[i].tu);
            force_hide = 1'(vecs[i].fh);
            tick();
            chk($sformatf("vec%0d", i), dut_outs(), exp_outs(vecs[i]));
        end
        clear_in();
        turn = 1'b0;

        // Load and open in the same cycle: open wins, load dropped.
        rst = 1'b1;
        tick();
        clear_in();
        load_en  = 1'b1;
        load_idx = 4'd6;
        load_val = 3'd7;
        open_en  = 1'b1;
        open_idx = 4'd6;
        tick();
        chk("load_open_same_cycle_ack", 64'({open_ack, open_val}), 64'({1'b1, 3'd3}));
        clear_in();
        force_hide = 1'b1;
        tick();
        clear_in();
        open_card(6);
        chk("load_dropped_val", 64'({open_ack, open_val}), 64'({1'b1, 3'd3}));
        force_hide = 1'b1;
        tick();
        clear_in();

        // Load honoured in IDLE with nothing matched.
        load_en  = 1'b1;
        load_idx = 4'd15;
        load_val = 3'd5;
        tick();
        clear_in();
        open_card(15);
        chk("load_honoured_val", 64'({open_ack, open_val, revealed}),
            64'({1'b1, 3'd5, 16'h8000}));
        force_hide = 1'b1;
        tick();
        clear_in();
        load_en  = 1'b1;
        load_idx = 4'd15;
        load_val = 3'd7;
        tick();
        clear_in();

        // Full game, alternating turn.
        rst = 1'b1;
        tick();
        clear_in();
        for (int p = 0; p < 8; p++) begin
            turn = 1'(p % 2);
            open_card(2 * p);
            open_card(2 * p + 1);
            tick();
            chk($sformatf("game_pair%0d", p), 64'({pair_valid, pair_match, pairs_left}),
                64'({1'b1, 1'b1, 4'(7 - p)}));
        end
        turn = 1'b0;
        chk("game_end", 64'({all_matched, matched, score0, score1}),
            64'({1'b1, 16'hFFFF, 4'd4, 4'd4}));
        chk("game_score_sum", 64'(score0 + score1), 64'd8);
        open_card(3);
        chk("open_after_game", 64'({open_ack, open_rej}), 64'({1'b0, 1'b1}));

        // Reset during SHOW_MISS.
        rst = 1'b1;
        tick();
        clear_in();
        open_card(0);
        open_card(1);
        tick();
        open_card(2);
        open_card(4);
        tick();
        tick();
        chk("miss_before_rst", 64'({busy, revealed, score0, pairs_left}),
            64'({1'b1, 16'h0017, 4'd1, 4'd7}));
        rst = 1'b1;
        tick();
        clear_in();
        chk("rst_in_show_miss", 64'({busy, revealed, matched, score0, score1, pairs_left}),
            64'({1'b0, 16'h0000, 16'h0000, 4'd0, 4'd0, 4'd8}));
        open_card(2);
        chk("open_after_rst", 64'({open_ack, busy, revealed}), 64'({1'b1, 1'b0, 16'h0004}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
